dma_burst_scheduler: RTL and testbench

- Shares one read-only memory port between NUM_REQ requesters in the accelerator IO path, e.g. image loader, weight loader and bias loader.
- Each requester posts a start address and a burst length.
- The block arbitrates between requesters, sequences consecutive addresses with a read enable, and returns the read words tagged with the owner's index.
- It signals a per-requester done pulse when the burst completes.

---
 rtl/dma_burst_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_dma_burst_scheduler.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_burst_scheduler.sv
// dma_burst_scheduler: shares one read-only memory port between NUM_REQ
// burst requesters. It arbitrates, sequences read addresses and returns the
// words tagged with the owner's index, then pulses done[owner].
// Build option: define DMA_SCHED_RR_EN for round-robin arbitration. Without it,
// the lowest requester index always wins.
//
// state | meaning
// IDLE  | no owner; arbitrate and latch winner's addr/len
// XFER  | issue len consecutive mem_en reads
// DRAIN | wait for the last word to leave the read pipeline, pulse done
module dma_burst_scheduler #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int LEN_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]   req_len,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         done,
  output logic                       busy,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic                       mem_en,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  output logic [$clog2(NUM_REQ)-1:0] out_id
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    owner_q, owner_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] grant_d, done_d;
  logic               busy_d, mem_en_d;
  logic [ADDR_W-1:0]  mem_addr_d;

  logic               win_found;
  logic [ID_W-1:0]    win_idx, cand;
  logic [NUM_REQ-1:0] win_oh;
  logic [ADDR_W-1:0]  win_addr;
  logic [LEN_W-1:0]   win_len;

  logic               rd_v_q;
  logic [ID_W-1:0]    rd_id_q;

`ifdef DMA_SCHED_RR_EN
  logic [ID_W-1:0]    ptr_q, ptr_d;
`endif

  // Pick the first requesting index, starting from the pointer (RR) or from 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef DMA_SCHED_RR_EN
      cand = ID_W'((int'(ptr_q) + k) % NUM_REQ);
`else
      cand = ID_W'(k);
`endif
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win_oh   = NUM_REQ'(1) << win_idx;
  assign win_addr = req_addr[win_idx*ADDR_W +: ADDR_W];
  assign win_len  = req_len[win_idx*LEN_W +: LEN_W];

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    grant_d    = grant;
    done_d     = '0;
    mem_en_d   = 1'b0;
    mem_addr_d = mem_addr;
`ifdef DMA_SCHED_RR_EN
    ptr_d      = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        grant_d = '0;
        // A zero-length done pulse occupies this IDLE cycle; arbitrate next one.
        if (win_found && (done == '0)) begin
          owner_d = win_idx;
          grant_d = win_oh;
`ifdef DMA_SCHED_RR_EN
          ptr_d   = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
`endif
          if (win_len != '0) begin
            state_d    = XFER;
            mem_en_d   = 1'b1;
            mem_addr_d = win_addr;
            cnt_d      = win_len - 1'b1;
          end else begin
            done_d = win_oh;
          end
        end
      end
      XFER: begin
        if (cnt_q != '0) begin
          mem_en_d   = 1'b1;
          mem_addr_d = mem_addr + 1'b1;
          cnt_d      = cnt_q - 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The last read is one stage from out_valid on entry to DRAIN.
        if (rd_v_q) begin
          done_d = grant;
        end else begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Control state and registered control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      cnt_q    <= '0;
      grant    <= '0;
      done     <= '0;
      busy     <= 1'b0;
      mem_en   <= 1'b0;
      mem_addr <= '0;
`ifdef DMA_SCHED_RR_EN
      ptr_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      grant    <= grant_d;
      done     <= done_d;
      busy     <= busy_d;
      mem_en   <= mem_en_d;
      mem_addr <= mem_addr_d;
`ifdef DMA_SCHED_RR_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

  // Two-stage read return: mem_en at t, mem_rdata at t+1, out_valid at t+2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_v_q    <= 1'b0;
      rd_id_q   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
    end else begin
      rd_v_q    <= mem_en;
      rd_id_q   <= owner_q;
      out_valid <= rd_v_q;
      if (rd_v_q) begin
        out_data <= mem_rdata;
        out_id   <= rd_id_q;
      end
    end
  end

endmodule

// File: tb/tb_dma_burst_scheduler.sv
// Scoreboard bench for dma_burst_scheduler: stimulus pushes expected
// addresses, words and done pulses; a negedge monitor pops and compares.
module tb_dma_burst_scheduler;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  req = '0;
  logic [47:0] req_addr = '0;
  logic [23:0] req_len = '0;
  logic [2:0]  grant, done;
  logic        busy, mem_en, out_valid;
  logic [15:0] mem_addr, out_data;
  logic [15:0] mem_rdata = '0;
  logic [1:0]  out_id;

  dma_burst_scheduler #(.NUM_REQ(3), .ADDR_W(16), .DATA_W(16), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_len(req_len),
    .grant(grant), .done(done), .busy(busy), .mem_addr(mem_addr),
    .mem_en(mem_en), .mem_rdata(mem_rdata), .out_data(out_data),
    .out_valid(out_valid), .out_id(out_id)
  );

  // 10-unit clock.
  always #5 clk = ~clk;

  int cyc = 0;
  // Cycle counter for latency checks.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] memf(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // Memory model: data one cycle after mem_en.
  always @(posedge clk) if (mem_en) mem_rdata <= memf(mem_addr);

  logic [15:0] exp_addr[$];
  logic [15:0] exp_data[$];
  int          exp_oid[$];
  int          exp_did[$];
  bit          exp_dbusy[$];

  int n_pass = 0, n_total = 0;
  int n_done = 0, n_en = 0;
  int first_en_cyc = 0, last_done_cyc = 0;
  bit prev_done = 0, prev_en = 0;
  logic [15:0] m_a;
  int          m_id;
  bit          m_b;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [2:0] oh(input int i);
    return 3'b001 << i;
  endfunction

  // Monitor: compare every presented output against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      prev_done = 0;
      prev_en   = 0;
    end else begin
      if (prev_done) chk(grant == 3'b000, "grant_drop", grant, 0);
      if (mem_en) begin
        if (!prev_en) first_en_cyc = cyc;
        n_en++;
        chk(exp_addr.size() != 0, "unexp_mem_en", mem_addr, 0);
        if (exp_addr.size() != 0) begin
          m_a = exp_addr.pop_front();
          chk(mem_addr == m_a, "mem_addr", mem_addr, m_a);
        end
      end
      if (out_valid) begin
        chk(exp_data.size() != 0, "unexp_out_valid", out_data, 0);
        if (exp_data.size() != 0) begin
          m_a  = exp_data.pop_front();
          m_id = exp_oid.pop_front();
          chk(out_data == m_a, "out_data", out_data, m_a);
          chk(out_id == 2'(m_id), "out_id", out_id, m_id);
          chk(grant == oh(m_id), "grant_owner", grant, oh(m_id));
        end
      end
      if (done != 3'b000) begin
        last_done_cyc = cyc;
        n_done++;
        chk(exp_did.size() != 0, "unexp_done", done, 0);
        if (exp_did.size() != 0) begin
          m_id = exp_did.pop_front();
          m_b  = exp_dbusy.pop_front();
          chk(done == oh(m_id), "done_id", done, oh(m_id));
          chk(grant == oh(m_id), "done_grant", grant, oh(m_id));
          chk(busy == m_b, "done_busy", busy, m_b);
          chk(out_valid == m_b, "done_last_word", out_valid, m_b);
        end
      end
      prev_done = (done != 3'b000);
      prev_en   = mem_en;
    end
  end

  task automatic set_req(input int i, input logic [15:0] a, input logic [7:0] l);
    req_addr[i*16 +: 16] = a;
    req_len[i*8 +: 8]    = l;
  endtask

  task automatic push_burst(input int id, input logic [15:0] a, input int len);
    for (int i = 0; i < len; i++) begin
      exp_addr.push_back(a + 16'(i));
      exp_data.push_back(memf(a + 16'(i)));
      exp_oid.push_back(id);
    end
    exp_did.push_back(id);
    exp_dbusy.push_back(len != 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_dones(input int target, input string name);
    int t = 0;
    while (n_done < target && t < 400) begin
      step();
      t++;
    end
    chk(n_done >= target, name, n_done, target);
  endtask

  task automatic wait_ens(input int target, input string name);
    int t = 0;
    while (n_en < target && t < 400) begin
      step();
      t++;
    end
    chk(n_en >= target, name, n_en, target);
  endtask

  initial begin
    int base;
    int zdone;
    #1 rst = 1'b1;
    #2;
    chk({grant, done, busy, mem_en, out_valid, out_id} == '0, "reset_ctl",
        {grant, done, busy, mem_en, out_valid, out_id}, 0);
    chk({mem_addr, out_data} == '0, "reset_data", {mem_addr, out_data}, 0);
    step();
    step();
    rst = 1'b0;

    // Contention from reset, all held, len=2 each.
    set_req(0, 16'h0040, 8'd2);
    set_req(1, 16'h0080, 8'd2);
    set_req(2, 16'h00C0, 8'd2);
`ifdef DMA_SCHED_RR_EN
    push_burst(0, 16'h0040, 2);
    push_burst(1, 16'h0080, 2);
    push_burst(2, 16'h00C0, 2);
    push_burst(0, 16'h0040, 2);
`else
    for (int i = 0; i < 4; i++) push_burst(0, 16'h0040, 2);
`endif
    req = 3'b111;
    wait_dones(4, "contention_timeout");
    req = 3'b000;
    repeat (3) step();

    // Single burst.
    set_req(0, 16'h0010, 8'd4);
    push_burst(0, 16'h0010, 4);
    req = 3'b001;
    wait_dones(5, "single_timeout");
    req = 3'b000;
    repeat (3) step();

    // Zero length, then the next request in the following IDLE.
    set_req(1, 16'h0050, 8'd0);
    push_burst(1, 16'h0050, 0);
    req = 3'b010;
    wait_dones(6, "zero_len_timeout");
    zdone = last_done_cyc;
    req = 3'b000;
    set_req(0, 16'h0020, 8'd2);
    push_burst(0, 16'h0020, 2);
    req = 3'b001;
    wait_dones(7, "after_zero_timeout");
    req = 3'b000;
    chk(first_en_cyc == zdone + 2, "zero_len_next_gap", first_en_cyc - zdone, 2);
    repeat (3) step();

    // Address wrap-around.
    set_req(0, 16'hFFFE, 8'd4);
    push_burst(0, 16'hFFFE, 4);
    req = 3'b001;
    wait_dones(8, "wrap_timeout");
    req = 3'b000;
    repeat (3) step();

    // Late req/len change during XFER.
    set_req(2, 16'h0200, 8'd3);
    push_burst(2, 16'h0200, 3);
    base = n_en;
    req = 3'b100;
    wait_ens(base + 1, "late_start_timeout");
    req = 3'b000;
    set_req(2, 16'h0400, 8'd7);
    wait_dones(9, "late_timeout");
    repeat (3) step();

    // Reset during the 3rd XFER cycle of a len=8 burst.
    set_req(0, 16'h0100, 8'd8);
    push_burst(0, 16'h0100, 8);
    base = n_en;
    req = 3'b001;
    wait_ens(base + 2, "rst_mid_start_timeout");
    rst = 1'b1;
    set_req(1, 16'h0300, 8'd1);
    req = 3'b011;
    #1;
    chk({grant, done, busy, mem_en, out_valid, out_id} == '0, "rst_mid_ctl",
        {grant, done, busy, mem_en, out_valid, out_id}, 0);
    chk({mem_addr, out_data} == '0, "rst_mid_data", {mem_addr, out_data}, 0);
    exp_addr.delete();
    exp_data.delete();
    exp_oid.delete();
    exp_did.delete();
    exp_dbusy.delete();
    repeat (2) step();
    push_burst(0, 16'h0100, 8);
    push_burst(1, 16'h0300, 1);
    base = n_done;
    rst = 1'b0;
    wait_dones(base + 1, "rst_restart_timeout");
    req = 3'b010;
    wait_dones(base + 2, "rst_second_timeout");
    req = 3'b000;
    repeat (4) step();

    chk(exp_addr.size() == 0, "leftover_addr", exp_addr.size(), 0);
    chk(exp_data.size() == 0, "leftover_data", exp_data.size(), 0);
    chk(exp_did.size() == 0, "leftover_done", exp_did.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
